// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing: req/ack word fetch, field decode and next-PC selection.
// Optional macro FETCH_TIMEOUT_EN adds an ack timeout that halts fetch and raises a sticky fault.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [31:0] pc,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        stall,
    output logic        fault
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {FETCH, ISSUE, HALT} state_t;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] wait_cnt;
`else
    typedef enum logic [0:0] {FETCH, ISSUE} state_t;
`endif

    state_t      state;
    logic [31:0] ir;

    // Jump beats branch; every target is word aligned, and 32-bit wrap is allowed.
    function automatic logic [31:0] calc_next_pc(input logic [31:0] cur_pc,
                                                 input logic [31:0] instr,
                                                 input logic        do_jump,
                                                 input logic        do_branch);
        logic        [31:0] pc4;
        logic signed [31:0] br_off;
        logic        [31:0] target;
        pc4    = cur_pc + 32'd4;
        br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
        if (do_jump)
            target = {pc4[31:28], instr[25:0], 2'b00};
        else if (do_branch)
            target = pc4 + $unsigned(br_off);
        else
            target = pc4;
        return {target[31:2], 2'b00};
    endfunction

    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == ISSUE);
    assign imem_addr   = pc;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= {RESET_PC[31:2], 2'b00};
            ir       <= '0;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= ISSUE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        fault <= 1'b1;
                        state <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc       <= calc_next_pc(pc, ir, jump, branch_taken);
                        wait_cnt <= '0;
                        state    <= FETCH;
                    end
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end
`else
    assign fault = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= {RESET_PC[31:2], 2'b00};
            ir    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc    <= calc_next_pc(pc, ir, jump, branch_taken);
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a behavioural PC/field model.
// Build with FETCH_TIMEOUT_EN defined to exercise the timeout/HALT path.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        stall = 1'b0;
    logic        fault;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] model_pc = 32'h0;
    logic [31:0] cur_word = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
        .imm(imm), .pc(pc), .branch_taken(branch_taken), .jump(jump), .stall(stall), .fault(fault)
    );

    // MIPS field layout of a word: opcode, rs, rt, rd, funct, imm
    function automatic logic [42:0] fields_of(input logic [31:0] w);
        return {w[31:26], w[25:21], w[20:16], w[15:11], w[5:0], w[15:0]};
    endfunction

    // Reference next-PC computed with plain arithmetic on the architectural rules
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                               input logic j, input logic b);
        logic [31:0] pc4;
        int          off;
        pc4 = cur + 32'd4;
        if (j) return (pc4 & 32'hF000_0000) + ((w & 32'h03FF_FFFF) * 32'd4);
        if (b) begin
            off = $signed(w[15:0]);
            off = off * 4;
            return pc4 + 32'(off);
        end
        return pc4;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        #1;
        total_cnt++;
        if ({imem_req, instr_valid, fault, pc} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            $display("FAIL reset_ctrl: got req=%b valid=%b fault=%b pc=%h, want req=1 valid=0 fault=0 pc=0",
                     imem_req, instr_valid, fault, pc);
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({opcode, rs, rt, rd, funct, imm, imem_addr} !== {43'd0, 32'h0}) begin
            $display("FAIL reset_fields: got fields=%h addr=%h, want 0 and 0",
                     {opcode, rs, rt, rd, funct, imm}, imem_addr);
        end else pass_cnt++;
        rst_n = 1'b1;
        model_pc = 32'h0;
    endtask

    task automatic fetch_word(input logic [31:0] word, input int waits);
        for (int k = 0; k <= waits; k++) begin
            total_cnt++;
            if ({imem_req, instr_valid, fault, imem_addr} !== {1'b1, 1'b0, 1'b0, model_pc}) begin
                $display("FAIL fetch_req: got req=%b valid=%b fault=%b addr=%h, want req=1 valid=0 fault=0 addr=%h",
                         imem_req, instr_valid, fault, imem_addr, model_pc);
            end else pass_cnt++;
            imem_ack   = (k == waits);
            imem_rdata = (k == waits) ? word : $urandom;
            @(negedge clk);
        end
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        cur_word   = word;
        total_cnt++;
        if ({instr_valid, imem_req, opcode, rs, rt, rd, funct, imm, pc} !==
            {1'b1, 1'b0, fields_of(word), model_pc}) begin
            $display("FAIL issue_fields: got valid=%b req=%b fields=%h pc=%h, want valid=1 req=0 fields=%h pc=%h",
                     instr_valid, imem_req, {opcode, rs, rt, rd, funct, imm}, pc, fields_of(word), model_pc);
        end else pass_cnt++;
    endtask

    task automatic issue_word(input logic j, input logic b, input int stalls);
        for (int k = 0; k < stalls; k++) begin
            stall = 1'b1; jump = 1'($urandom); branch_taken = 1'($urandom); imem_ack = 1'($urandom);
            @(negedge clk);
            total_cnt++;
            if ({instr_valid, imem_req, opcode, rs, rt, rd, funct, imm, pc} !==
                {1'b1, 1'b0, fields_of(cur_word), model_pc}) begin
                $display("FAIL stall_hold: got valid=%b req=%b fields=%h pc=%h, want valid=1 req=0 fields=%h pc=%h",
                         instr_valid, imem_req, {opcode, rs, rt, rd, funct, imm}, pc, fields_of(cur_word), model_pc);
            end else pass_cnt++;
        end
        stall = 1'b0; jump = j; branch_taken = b; imem_ack = 1'b0;
        model_pc = model_next(model_pc, cur_word, j, b);
        @(negedge clk);
        jump = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_zero_wait();
        fetch_word(32'h2001_0005, 0);
        total_cnt++;
        if ({opcode, rt, imm} !== {6'h08, 5'd1, 16'd5}) begin
            $display("FAIL addi_fields: got op=%h rt=%0d imm=%h, want op=08 rt=1 imm=0005", opcode, rt, imm);
        end else pass_cnt++;
        issue_word(1'b0, 1'b0, 0);
        total_cnt++;
        if (imem_addr !== 32'h4) begin
            $display("FAIL second_addr: got %h, want 00000004", imem_addr);
        end else pass_cnt++;
        fetch_word(32'h0022_1820, 0);
        total_cnt++;
        if ({opcode, funct, rd} !== {6'h00, 6'h20, 5'd3}) begin
            $display("FAIL add_fields: got op=%h funct=%h rd=%0d, want op=00 funct=20 rd=3", opcode, funct, rd);
        end else pass_cnt++;
        issue_word(1'b0, 1'b0, 0);
    endtask

    task automatic test_wait_states();
        fetch_word(32'h8C43_0010, 3);
        issue_word(1'b0, 1'b0, 0);
    endtask

    task automatic test_branch();
        fetch_word(32'h0800_0010, 0);
        issue_word(1'b1, 1'b0, 0);
        total_cnt++;
        if (imem_addr !== 32'h40) begin
            $display("FAIL jump_to_40: got %h, want 00000040", imem_addr);
        end else pass_cnt++;
        fetch_word(32'h1000_FFFE, 0);
        issue_word(1'b0, 1'b1, 0);
        total_cnt++;
        if (imem_addr !== 32'h3C) begin
            $display("FAIL branch_taken: got %h, want 0000003c", imem_addr);
        end else pass_cnt++;
        fetch_word(32'h0800_0010, 1);
        issue_word(1'b1, 1'b0, 0);
        fetch_word(32'h1000_FFFE, 0);
        issue_word(1'b0, 1'b0, 0);
        total_cnt++;
        if (imem_addr !== 32'h44) begin
            $display("FAIL branch_not_taken: got %h, want 00000044", imem_addr);
        end else pass_cnt++;
    endtask

    task automatic test_jump();
        fetch_word(32'h0BFF_FFFE, 0);
        issue_word(1'b1, 1'b0, 0);
        fetch_word($urandom, 0);
        issue_word(1'b0, 1'b0, 0);
        fetch_word($urandom, 0);
        issue_word(1'b0, 1'b0, 0);
        total_cnt++;
        if (imem_addr !== 32'h1000_0000) begin
            $display("FAIL region_cross: got %h, want 10000000", imem_addr);
        end else pass_cnt++;
        fetch_word(32'h0800_0004, 0);
        issue_word(1'b1, 1'b0, 0);
        total_cnt++;
        if (imem_addr !== 32'h1000_0010) begin
            $display("FAIL jump_to_10: got %h, want 10000010", imem_addr);
        end else pass_cnt++;
        fetch_word(32'h0800_0100, 0);
        issue_word(1'b1, 1'b1, 0);
        total_cnt++;
        if (imem_addr !== 32'h1000_0400) begin
            $display("FAIL jump_priority: got %h, want 10000400", imem_addr);
        end else pass_cnt++;
    endtask

    task automatic test_stall();
        apply_reset();
        fetch_word(32'h1000_FFFE, 0);
        issue_word(1'b0, 1'b1, 0);
        total_cnt++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            $display("FAIL branch_wrap: got %h, want fffffffc", imem_addr);
        end else pass_cnt++;
        fetch_word($urandom, 2);
        issue_word(1'b0, 1'b0, 5);
        total_cnt++;
        if (imem_addr !== 32'h0) begin
            $display("FAIL seq_wrap: got %h, want 00000000", imem_addr);
        end else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            fetch_word($urandom, int'($urandom_range(0, 3)));
            issue_word(1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_mid();
        fetch_word(32'h0800_0010, 0);
        issue_word(1'b1, 1'b0, 0);
        rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        total_cnt++;
        if ({imem_req, instr_valid, pc} !== {1'b1, 1'b0, 32'h0}) begin
            $display("FAIL midreset_async: got req=%b valid=%b pc=%h, want req=1 valid=0 pc=0",
                     imem_req, instr_valid, pc);
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({instr_valid, opcode, rs, rt, rd, funct, imm} !== 44'd0) begin
            $display("FAIL midreset_ack: got valid=%b fields=%h, want valid=0 fields=0",
                     instr_valid, {opcode, rs, rt, rd, funct, imm});
        end else pass_cnt++;
        rst_n = 1'b1; imem_ack = 1'b0;
        model_pc = 32'h0;
        fetch_word(32'h2001_0005, 0);
        issue_word(1'b0, 1'b0, 0);
    endtask

    task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            total_cnt++;
            if ({imem_req, fault} !== 2'b10) begin
                $display("FAIL timeout_wait: cycle %0d got req=%b fault=%b, want req=1 fault=0", k, imem_req, fault);
            end else pass_cnt++;
            imem_ack = 1'b0;
            @(negedge clk);
        end
        total_cnt++;
        if ({imem_req, instr_valid, fault} !== 3'b001) begin
            $display("FAIL timeout_halt: got req=%b valid=%b fault=%b, want req=0 valid=0 fault=1",
                     imem_req, instr_valid, fault);
        end else pass_cnt++;
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        total_cnt++;
        if ({imem_req, instr_valid, fault} !== 3'b001) begin
            $display("FAIL halt_sticky: got req=%b valid=%b fault=%b, want req=0 valid=0 fault=1",
                     imem_req, instr_valid, fault);
        end else pass_cnt++;
        apply_reset();
        fetch_word(32'h0022_1820, 0);
        issue_word(1'b0, 1'b0, 0);
`else
        for (int k = 0; k < 20; k++) begin
            total_cnt++;
            if ({imem_req, fault, imem_addr} !== {2'b10, model_pc}) begin
                $display("FAIL long_wait: cycle %0d got req=%b fault=%b addr=%h, want req=1 fault=0 addr=%h",
                         k, imem_req, fault, imem_addr, model_pc);
            end else pass_cnt++;
            imem_ack = 1'b0;
            @(negedge clk);
        end
        fetch_word(32'h0022_1820, 0);
        issue_word(1'b0, 1'b0, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch();
        test_jump();
        test_stall();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
